q_row_fetch: RTL and testbench

Upstream feeder for `action_determiner`. On a `start` request it reads the four Q-table entries of one state from the external synchronous Q-table RAM, one action per cycle. It computes their signed maximum and the index of that maximum, and presents `in0..in3`/`q_max` on stable registered outputs. It also keeps the 12-bit `iteration` count consumed by the explore/exploit decision.

---
 rtl/q_row_fetch.sv | 156 +++++++++++++++
 tb/tb_q_row_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_row_fetch.sv
// Fetches the four Q-values of one state from a synchronous RAM, tracks the signed max and its
// index, and publishes the row on registered outputs with a one-cycle valid pulse.
module q_row_fetch #(
   parameter int unsigned STATE_W = 6,
   parameter int unsigned Q_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] state,
   output logic               busy,
   output logic               mem_rd_en,
   output logic [STATE_W+1:0] mem_addr,
   input  logic [Q_W-1:0]     mem_rd_data,
   output logic [Q_W-1:0]     in0,
   output logic [Q_W-1:0]     in1,
   output logic [Q_W-1:0]     in2,
   output logic [Q_W-1:0]     in3,
   output logic [Q_W-1:0]     q_max,
   output logic [1:0]         qmax_idx,
   output logic               valid,
   output logic [11:0]        iteration
);

   typedef enum logic [1:0] {StIdle, StRead, StLast, StDone} st_e;

   st_e                st_q, st_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [1:0]         a_q, a_d;
   logic [1:0]         ad_q, ad_d;
   logic               cap_q, cap_d;
   logic               busy_q, busy_d;
   logic               rd_en_q, rd_en_d;
   logic [Q_W-1:0]     w_q [4];
   logic [Q_W-1:0]     w_d [4];
   logic [Q_W-1:0]     max_q, max_d;
   logic [1:0]         idx_q, idx_d;
   logic [Q_W-1:0]     out_q [4];
   logic [Q_W-1:0]     out_d [4];
   logic [Q_W-1:0]     qmax_q, qmax_d;
   logic [1:0]         qidx_q, qidx_d;
   logic               valid_q, valid_d;
   logic [11:0]        iter_q, iter_d;

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      a_d     = a_q;
      ad_d    = a_q;
      cap_d   = rd_en_q;
      busy_d  = busy_q;
      rd_en_d = rd_en_q;
      w_d     = w_q;
      max_d   = max_q;
      idx_d   = idx_q;
      out_d   = out_q;
      qmax_d  = qmax_q;
      qidx_d  = qidx_q;
      valid_d = 1'b0;
      iter_d  = iter_q;

      // Data for the read issued last cycle; strict compare keeps the lowest index on ties.
      if (cap_q) begin
         w_d[ad_q] = mem_rd_data;
         if (ad_q == 2'd0 || $signed(mem_rd_data) > $signed(max_q)) begin
            max_d = mem_rd_data;
            idx_d = ad_q;
         end
      end

      unique case (st_q)
         StIdle, StDone: begin
            st_d = StIdle;
            if (start) begin
               st_d    = StRead;
               state_d = state;
               a_d     = 2'd0;
               busy_d  = 1'b1;
               rd_en_d = 1'b1;
            end
         end
         StRead: begin
            a_d = a_q + 2'd1;
            if (a_q == 2'd3) begin
               rd_en_d = 1'b0;
               st_d    = StLast;
            end
         end
         StLast: begin
            // w[3] arrives this cycle, so the outputs take it straight from the RAM.
            st_d     = StDone;
            busy_d   = 1'b0;
            valid_d  = 1'b1;
            out_d[0] = w_q[0];
            out_d[1] = w_q[1];
            out_d[2] = w_q[2];
            out_d[3] = mem_rd_data;
            qmax_d   = max_d;
            qidx_d   = idx_d;
            if (iter_q != 12'hFFF) iter_d = iter_q + 12'd1;
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= StIdle;
         state_q <= '0;
         a_q     <= '0;
         ad_q    <= '0;
         cap_q   <= 1'b0;
         busy_q  <= 1'b0;
         rd_en_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            w_q[i]   <= '0;
            out_q[i] <= '0;
         end
         max_q   <= '0;
         idx_q   <= '0;
         qmax_q  <= '0;
         qidx_q  <= '0;
         valid_q <= 1'b0;
         iter_q  <= '0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         a_q     <= a_d;
         ad_q    <= ad_d;
         cap_q   <= cap_d;
         busy_q  <= busy_d;
         rd_en_q <= rd_en_d;
         w_q     <= w_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         qmax_q  <= qmax_d;
         qidx_q  <= qidx_d;
         valid_q <= valid_d;
         iter_q  <= iter_d;
      end
   end

   assign busy      = busy_q;
   assign mem_rd_en = rd_en_q;
   assign mem_addr  = {state_q, a_q};
   assign in0       = out_q[0];
   assign in1       = out_q[1];
   assign in2       = out_q[2];
   assign in3       = out_q[3];
   assign q_max     = qmax_q;
   assign qmax_idx  = qidx_q;
   assign valid     = valid_q;
   assign iteration = iter_q;

endmodule

// File: tb/tb_q_row_fetch.sv
// Directed bench for q_row_fetch: table of rows plus back-to-back, mid-fetch reset and
// iteration saturation sequences against a behavioural synchronous RAM.
module tb_q_row_fetch;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [5:0]  state;
   logic        busy, mem_rd_en, valid;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rd_data;
   logic [31:0] in0, in1, in2, in3, q_max;
   logic [1:0]  qmax_idx;
   logic [11:0] iteration;

   logic [31:0] ram [256];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= ram[mem_addr];
   end

   q_row_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .state      (state),
      .busy       (busy),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .in0        (in0),
      .in1        (in1),
      .in2        (in2),
      .in3        (in3),
      .q_max      (q_max),
      .qmax_idx   (qmax_idx),
      .valid      (valid),
      .iteration  (iteration)
   );

   typedef struct {
      logic [5:0]       s;
      logic [3:0][31:0] row;
      logic [31:0]      mx;
      logic [1:0]       idx;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [5:0] s, input logic [31:0] r0,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
                          input logic [31:0] mx, input logic [1:0] idx);
      vecs[i].s   = s;
      vecs[i].row = {r3, r2, r1, r0};
      vecs[i].mx  = mx;
      vecs[i].idx = idx;
   endtask

   task automatic load_row(input int i);
      for (int k = 0; k < 4; k++) ram[{vecs[i].s, 2'(k)}] = vecs[i].row[k];
   endtask

   task automatic chk_row(input string tag, input int i);
      chk({tag, "_in0"}, in0, vecs[i].row[0]);
      chk({tag, "_in1"}, in1, vecs[i].row[1]);
      chk({tag, "_in2"}, in2, vecs[i].row[2]);
      chk({tag, "_in3"}, in3, vecs[i].row[3]);
      chk({tag, "_qmax"}, q_max, vecs[i].mx);
      chk({tag, "_idx"}, {30'b0, qmax_idx}, {30'b0, vecs[i].idx});
   endtask

   // Caller drives start/state before a rising edge; returns edges from T0 to valid (-1 = none).
   task automatic run_fetch(input logic [5:0] s, input bit poke, input bit hold,
                            input logic [31:0] hold_in0, input logic [31:0] hold_max,
                            output int lat);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_t0", {31'b0, busy}, 32'd1);
      chk("rd_en_a0", {31'b0, mem_rd_en}, 32'd1);
      chk("addr_a0", {24'b0, mem_addr}, {24'b0, s, 2'd0});
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (n <= 3) begin
            chk("rd_en_read", {31'b0, mem_rd_en}, 32'd1);
            chk("addr_read", {24'b0, mem_addr}, {24'b0, s, 2'(n)});
         end
         if (n == 4) begin
            chk("rd_en_last", {31'b0, mem_rd_en}, 32'd0);
            chk("busy_last", {31'b0, busy}, 32'd1);
         end
         if (poke && n == 2) begin
            start = 1'b1;
            state = 6'd7;
         end
         if (poke && n == 3) start = 1'b0;
         if (hold && !valid) begin
            chk("hold_in0", in0, hold_in0);
            chk("hold_qmax", q_max, hold_max);
         end
         if (valid) begin
            lat = n;
            chk("busy_in_valid", {31'b0, busy}, 32'd0);
            break;
         end
      end
   endtask

   task automatic wait_valid(input int bound, output bit found);
      found = 1'b0;
      for (int n = 0; n < bound; n++) begin
         @(posedge clk); #1;
         if (valid) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      bit found;
      int n;

      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      set_vec(0, 6'd5,  32'd10, 32'hFFFF_FFFD, 32'd42, 32'd7, 32'd42, 2'd2);
      set_vec(1, 6'd1,  32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFF7,
              32'hFFFF_FFFB, 2'd0);
      set_vec(2, 6'd2,  32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 2'd0);
      set_vec(3, 6'd63, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
              32'h7FFF_FFFF, 2'd3);
      set_vec(4, 6'd0,  32'd1, 32'd5, 32'd5, 32'd2, 32'd5, 2'd1);
      set_vec(5, 6'd10, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 2'd3);
      for (int i = 0; i < 6; i++) load_row(i);

      // Reset, then idle with no start.
      rst = 1'b1; start = 1'b0; state = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_addr", {24'b0, mem_addr}, 32'd0);
      chk("rst_in0", in0, 32'd0);
      chk("rst_in3", in3, 32'd0);
      chk("rst_qmax", q_max, 32'd0);
      chk("rst_idx", {30'b0, qmax_idx}, 32'd0);
      chk("rst_iter", {20'b0, iteration}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("idle_rd_en", {31'b0, mem_rd_en}, 32'd0);
         chk("idle_valid", {31'b0, valid}, 32'd0);
      end

      // Table of single fetches.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b1;
         state = vecs[i].s;
         run_fetch(vecs[i].s, 1'b0, 1'b0, '0, '0, lat);
         chk("latency", lat, 32'd5);
         chk_row("vec", i);
         chk("vec_iter", {20'b0, iteration}, 32'(i + 1));
         @(posedge clk); #1;
         chk("valid_pulse", {31'b0, valid}, 32'd0);
      end

      // Back-to-back: restart in the valid cycle; a start pulse during busy must be ignored.
      @(negedge clk);
      start = 1'b1;
      state = vecs[0].s;
      run_fetch(vecs[0].s, 1'b0, 1'b0, '0, '0, lat);
      chk("b2b_first_lat", lat, 32'd5);
      chk_row("b2b_first", 0);
      start = 1'b1;
      state = 6'd63;
      run_fetch(6'd63, 1'b1, 1'b1, vecs[0].row[0], vecs[0].mx, lat);
      chk("b2b_interval", lat, 32'd5);
      chk_row("b2b_second", 3);
      chk("b2b_iter", {20'b0, iteration}, 32'd8);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("no_extra_valid", {31'b0, valid}, 32'd0);
         chk("no_extra_read", {31'b0, mem_rd_en}, 32'd0);
      end

      // Reset at T0+3 aborts the fetch.
      @(negedge clk);
      start = 1'b1;
      state = vecs[1].s;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_rd_en", {31'b0, mem_rd_en}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_in0", in0, 32'd0);
      chk("abort_qmax", q_max, 32'd0);
      chk("abort_iter", {20'b0, iteration}, 32'd0);
      wait_valid(10, found);
      chk("abort_no_valid", {31'b0, found}, 32'd0);
      @(negedge clk);
      start = 1'b1;
      state = vecs[4].s;
      run_fetch(vecs[4].s, 1'b0, 1'b0, '0, '0, lat);
      chk("after_abort_lat", lat, 32'd5);
      chk_row("after_abort", 4);
      chk("after_abort_iter", {20'b0, iteration}, 32'd1);

      // Saturation: keep start high until the counter reaches FFE, then two more fetches.
      @(negedge clk);
      start = 1'b1;
      state = 6'd2;
      n = 0;
      while (iteration != 12'hFFE && n < 30000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("sat_reach_ffe", {20'b0, iteration}, 32'hFFE);
      wait_valid(10, found);
      chk("sat_valid1", {31'b0, found}, 32'd1);
      chk("sat_fff", {20'b0, iteration}, 32'hFFF);
      wait_valid(10, found);
      start = 1'b0;
      chk("sat_valid2", {31'b0, found}, 32'd1);
      chk("sat_hold_fff", {20'b0, iteration}, 32'hFFF);
      chk("sat_row_qmax", q_max, vecs[2].mx);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
